// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: raw keypad rows/columns plus the
// debounced key stream presented to the lock decider.
interface keypad_scanner_if;
   logic [3:0] row_in;   // keypad rows, active-low, asynchronous to clk
   logic [2:0] col_out;  // column strobes, active-low, one-cold
   logic [3:0] Code_1;   // encoded key, stable between accepted presses
   logic       Valid_1;  // press-accepted pulse
   logic       S_Row;    // debounced key-held flag

   // Scanner side: reads the rows, drives the strobes and the key stream
   modport master (
      input  row_in,
      output col_out,
      output Code_1,
      output Valid_1,
      output S_Row
   );

   // Keypad/consumer side
   modport slave (
      output row_in,
      input  col_out,
      input  Code_1,
      input  Valid_1,
      input  S_Row
   );
endinterface

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column strobing, 2-flop row synchronizer,
// per-round classification (none / single key / multiple keys), round-based
// press/release debouncing and a fixed-width press-accepted pulse.
module keypad_scanner #(
   parameter int SCAN_DIV  = 1000,  // clk cycles per column slot
   parameter int DEB_CNT   = 16,    // identical rounds to accept press/release
   parameter int VALID_LEN = 4      // Valid_1 pulse width in clk cycles
) (
   input  logic              clk,
   input  logic              reset_1,
   keypad_scanner_if.master  kp
);

   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W  = $clog2(DEB_CNT + 1);
   localparam int VLD_W  = (VALID_LEN > 1) ? $clog2(VALID_LEN) : 1;

   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
   localparam logic [SLOT_W-1:0] SLOT_ONE   = SLOT_W'(1);
   localparam logic [DEB_W-1:0]  DEB_MAX    = DEB_W'(DEB_CNT);
   localparam logic [DEB_W-1:0]  DEB_ONE    = DEB_W'(1);
   localparam logic [VLD_W-1:0]  VLD_RELOAD = VLD_W'(VALID_LEN - 1);
   localparam logic [VLD_W-1:0]  VLD_ONE    = VLD_W'(1);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED} state_t;

   // Number of rows pulled low in one sample
   function automatic logic [2:0] count_low(input logic [3:0] low);
      return 3'(low[0]) + 3'(low[1]) + 3'(low[2]) + 3'(low[3]);
   endfunction

   // Index of the low row; only meaningful when exactly one row is low
   function automatic logic [1:0] row_index(input logic [3:0] low);
      if (low[0])      return 2'd0;
      else if (low[1]) return 2'd1;
      else if (low[2]) return 2'd2;
      else             return 2'd3;
   endfunction

   // Key code for a row/column intersection
   function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
      case ({row, col})
         4'b00_00: return 4'b0001;  // 1
         4'b00_01: return 4'b0010;  // 2
         4'b00_10: return 4'b0011;  // 3
         4'b01_00: return 4'b0100;  // 4
         4'b01_01: return 4'b0101;  // 5
         4'b01_10: return 4'b0110;  // 6
         4'b10_00: return 4'b0111;  // 7
         4'b10_01: return 4'b1000;  // 8
         4'b10_10: return 4'b1001;  // 9
         4'b11_00: return 4'b1011;  // *
         4'b11_01: return 4'b0000;  // 0
         4'b11_10: return 4'b1010;  // #
         default:  return 4'b0000;
      endcase
   endfunction

   logic [3:0]        sync_p0, sync_p1;
   logic [SLOT_W-1:0] slot_cnt;
   logic [1:0]        col_idx;
   logic [2:0]        col_reg;
   logic [1:0]        acc_cnt;   // intersections seen so far this round, saturates at 2
   logic [3:0]        acc_code;  // code of the first intersection seen this round

   state_t            state;
   logic [3:0]        cand;
   logic [DEB_W-1:0]  deb, rel;
   logic [3:0]        code_reg;
   logic              held_reg;
   logic              vld_arm;
   logic [VLD_W-1:0]  vld_left;
   logic              vld_reg;

   logic [3:0]        row_low;
   logic [2:0]        n_low;
   logic [1:0]        n_sat;
   logic [2:0]        hit_sum;
   logic [3:0]        sample_code;
   logic              slot_end, round_end;
   logic              rnd_none, rnd_key;
   logic [3:0]        rnd_code;

   // Classify the current sample and fold it into the round result
   always_comb begin
      row_low     = ~sync_p1;
      n_low       = count_low(row_low);
      n_sat       = (n_low > 3'd1) ? 2'd2 : n_low[1:0];
      sample_code = encode_key(row_index(row_low), col_idx);
      slot_end    = (slot_cnt == SLOT_LAST);
      round_end   = slot_end && (col_idx == 2'd2);
      hit_sum     = {1'b0, acc_cnt} + {1'b0, n_sat};
      rnd_none    = (hit_sum == 3'd0);
      rnd_key     = (hit_sum == 3'd1);
      rnd_code    = (acc_cnt == 2'd1) ? acc_code : sample_code;
   end

   // Row synchronizer, column strobing and per-round intersection accumulation
   always_ff @(posedge clk or negedge reset_1) begin
      if (!reset_1) begin
         sync_p0  <= 4'b1111;
         sync_p1  <= 4'b1111;
         slot_cnt <= '0;
         col_idx  <= 2'd0;
         col_reg  <= 3'b110;
         acc_cnt  <= 2'd0;
         acc_code <= 4'b0000;
      end else begin
         // stage p0 -> p1: metastability filter on the asynchronous rows
         sync_p0 <= kp.row_in;
         sync_p1 <= sync_p0;
         if (slot_end) begin
            slot_cnt <= '0;
            col_reg  <= {col_reg[1:0], col_reg[2]};
            if (col_idx == 2'd2) begin
               col_idx <= 2'd0;
               acc_cnt <= 2'd0;
            end else begin
               col_idx <= col_idx + 2'd1;
               acc_cnt <= (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
               if (acc_cnt == 2'd0 && n_sat == 2'd1)
                  acc_code <= sample_code;
            end
         end else begin
            slot_cnt <= slot_cnt + SLOT_ONE;
         end
      end
   end

   // Debounce FSM with registered key code, held flag and Valid_1 pulse
   always_ff @(posedge clk or negedge reset_1) begin
      if (!reset_1) begin
         state    <= IDLE;
         cand     <= 4'b0000;
         deb      <= '0;
         rel      <= '0;
         code_reg <= 4'b0000;
         held_reg <= 1'b0;
         vld_arm  <= 1'b0;
         vld_left <= '0;
         vld_reg  <= 1'b0;
      end else begin
         // Pulse starts the cycle after the accept so Code_1 leads it by one cycle
         vld_arm <= 1'b0;
         if (vld_arm) begin
            vld_reg  <= 1'b1;
            vld_left <= VLD_RELOAD;
         end else if (vld_left != '0) begin
            vld_reg  <= 1'b1;
            vld_left <= vld_left - VLD_ONE;
         end else begin
            vld_reg  <= 1'b0;
         end

         if (round_end) begin
            unique case (state)
               IDLE: begin
                  if (rnd_key) begin
                     cand <= rnd_code;
                     if (DEB_CNT <= 1) begin
                        code_reg <= rnd_code;
                        held_reg <= 1'b1;
                        vld_arm  <= 1'b1;
                        deb      <= DEB_MAX;
                        rel      <= '0;
                        state    <= PRESSED;
                     end else begin
                        deb   <= DEB_ONE;
                        state <= DEBOUNCE;
                     end
                  end
               end
               DEBOUNCE: begin
                  if (rnd_key && rnd_code == cand) begin
                     if (deb + DEB_ONE >= DEB_MAX) begin
                        code_reg <= cand;
                        held_reg <= 1'b1;
                        vld_arm  <= 1'b1;
                        deb      <= DEB_MAX;
                        rel      <= '0;
                        state    <= PRESSED;
                     end else begin
                        deb <= deb + DEB_ONE;
                     end
                  end else begin
                     deb   <= '0;
                     state <= IDLE;
                  end
               end
               PRESSED: begin
                  // Any activity while held (including a different key) only restarts release timing
                  if (rnd_none) begin
                     if (rel + DEB_ONE >= DEB_MAX) begin
                        rel      <= '0;
                        deb      <= '0;
                        held_reg <= 1'b0;
                        state    <= IDLE;
                     end else begin
                        rel <= rel + DEB_ONE;
                     end
                  end else begin
                     rel <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign kp.col_out = col_reg;
   assign kp.Code_1  = code_reg;
   assign kp.Valid_1 = vld_reg;
   assign kp.S_Row   = held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model answers the column strobes,
// directed press sequences push expected key events into a scoreboard and a
// monitor checks every Valid_1 pulse (code, latency, width) against it.
`timescale 1ns/1ps
module tb_keypad_scanner;

   localparam int SCAN_DIV  = 4;
   localparam int DEB_CNT   = 3;
   localparam int VALID_LEN = 4;
   localparam int ROUND     = 3 * SCAN_DIV;
   localparam int LATENCY   = DEB_CNT * ROUND + 1;

   logic clk = 1'b0;
   logic reset_1 = 1'b0;

   // Free-running clock
   always #5 clk = ~clk;

   keypad_scanner_if kif();

   keypad_scanner #(
      .SCAN_DIV  (SCAN_DIV),
      .DEB_CNT   (DEB_CNT),
      .VALID_LEN (VALID_LEN)
   ) dut (
      .clk     (clk),
      .reset_1 (reset_1),
      .kp      (kif)
   );

   // Keypad model: keys[r][c] pressed pulls row r low while column c is strobed
   logic [3:0][2:0] keys = '0;
   logic [3:0]      rows;
   always_comb begin
      rows = 4'b1111;
      for (int r = 0; r < 4; r++)
         rows[r] = ~(|(keys[r] & ~kif.col_out));
   end
   assign kif.row_in = rows;

   int unsigned cyc = 0;
   // Posedge count, used to time expected Valid_1 rises
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passed = 0;

   typedef struct {
      logic [3:0]  code;
      int unsigned due;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input int actual, input int required);
      checks++;
      if (actual == required) passed++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, required, cyc);
   endtask

   // Monitor: pops the scoreboard on each Valid_1 rise and checks pulse width
   initial begin
      logic mon_prev;
      int   mon_width;
      exp_t e;
      mon_prev  = 1'b0;
      mon_width = 0;
      forever begin
         @(negedge clk);
         if (!reset_1) begin
            mon_prev  = 1'b0;
            mon_width = 0;
         end else begin
            if (kif.Valid_1 && !mon_prev) begin
               check("valid_was_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check("valid_code", int'(kif.Code_1), int'(e.code));
                  check("valid_latency", int'(cyc), int'(e.due));
               end
               mon_width = 1;
            end else if (kif.Valid_1) begin
               mon_width++;
            end else if (mon_prev) begin
               check("valid_width", mon_width, VALID_LEN);
            end
            mon_prev = kif.Valid_1;
         end
      end
   end

   task automatic wait_round_start();
      logic [2:0] last;
      bit         found;
      last  = kif.col_out;
      found = 1'b0;
      for (int i = 0; i < 2 * ROUND && !found; i++) begin
         @(negedge clk);
         if (kif.col_out == 3'b110 && last == 3'b011) found = 1'b1;
         last = kif.col_out;
      end
      check("round_start_seen", int'(found), 1);
   endtask

   task automatic wait_rounds(input int n);
      for (int i = 0; i < n; i++) wait_round_start();
   endtask

   task automatic press(input int r, input int c);
      keys[r][c] = 1'b1;
   endtask

   task automatic release_all();
      keys = '0;
   endtask

   task automatic expect_press(input logic [3:0] code);
      exp_t e;
      e.code = code;
      e.due  = cyc + LATENCY;
      exp_q.push_back(e);
   endtask

   // Hard stop in case the run wanders off
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   // Directed stimulus
   initial begin
      bit seen;
      reset_1 = 1'b0;
      release_all();
      repeat (3) @(negedge clk);
      #1;
      check("reset_col_out", int'(kif.col_out), 6);
      check("reset_code", int'(kif.Code_1), 0);
      check("reset_valid", int'(kif.Valid_1), 0);
      check("reset_s_row", int'(kif.S_Row), 0);
      @(negedge clk);
      reset_1 = 1'b1;

      // '5' held 5 rounds, then released
      wait_round_start();
      press(1, 1);
      expect_press(4'b0101);
      wait_rounds(2);
      check("t1_s_row_before_accept", int'(kif.S_Row), 0);
      wait_rounds(1);
      check("t1_code", int'(kif.Code_1), 5);
      check("t1_s_row_held", int'(kif.S_Row), 1);
      wait_rounds(2);
      release_all();
      wait_rounds(2);
      check("t1_s_row_release_pending", int'(kif.S_Row), 1);
      wait_rounds(1);
      check("t1_s_row_released", int'(kif.S_Row), 0);
      wait_rounds(1);

      // '#' then '*'
      press(3, 2);
      expect_press(4'b1010);
      wait_rounds(3);
      check("t2_code_hash", int'(kif.Code_1), 10);
      wait_rounds(1);
      release_all();
      wait_rounds(4);
      check("t2_s_row_between", int'(kif.S_Row), 0);
      check("t2_code_holds", int'(kif.Code_1), 10);
      press(3, 0);
      expect_press(4'b1011);
      wait_rounds(3);
      check("t2_code_star", int'(kif.Code_1), 11);
      release_all();
      wait_rounds(4);

      // Bounce on '7': 2 rounds, gap, 3 rounds
      press(2, 0);
      wait_rounds(2);
      check("t3_code_during_bounce", int'(kif.Code_1), 11);
      release_all();
      wait_rounds(1);
      press(2, 0);
      expect_press(4'b0111);
      wait_rounds(3);
      check("t3_code", int'(kif.Code_1), 7);
      release_all();
      wait_rounds(4);

      // '1' and '2' together: rejected
      press(0, 0);
      press(0, 1);
      wait_rounds(6);
      check("t4_code_kept", int'(kif.Code_1), 7);
      check("t4_s_row", int'(kif.S_Row), 0);
      release_all();
      wait_rounds(1);

      // '#' held 20 rounds, switching to '0' mid-hold
      press(3, 2);
      expect_press(4'b1010);
      wait_rounds(3);
      check("t5_code", int'(kif.Code_1), 10);
      for (int i = 0; i < 17; i++) begin
         if (i == 7) begin
            release_all();
            press(3, 1);
         end
         wait_rounds(1);
         check("t5_s_row_held", int'(kif.S_Row), 1);
      end
      release_all();
      wait_rounds(4);
      check("t5_s_row_released", int'(kif.S_Row), 0);
      check("t5_code_no_zero_event", int'(kif.Code_1), 10);

      // Reset asserted in the middle of a Valid_1 pulse
      press(0, 0);
      expect_press(4'b0001);
      seen = 1'b0;
      for (int i = 0; i < LATENCY + 2 * ROUND && !seen; i++) begin
         @(negedge clk);
         if (kif.Valid_1) seen = 1'b1;
      end
      check("t6_valid_seen", int'(seen), 1);
      @(negedge clk);
      #2 reset_1 = 1'b0;
      #1;
      check("t6_valid_abort", int'(kif.Valid_1), 0);
      check("t6_s_row_abort", int'(kif.S_Row), 0);
      check("t6_code_abort", int'(kif.Code_1), 0);
      check("t6_col_abort", int'(kif.col_out), 6);
      release_all();
      @(negedge clk);
      @(negedge clk);
      #2 reset_1 = 1'b1;
      repeat (3) @(negedge clk);
      check("t6_col0_after_reset", int'(kif.col_out), 6);
      @(negedge clk);
      check("t6_col1_after_reset", int'(kif.col_out), 5);

      repeat (2 * ROUND) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Matrix-keypad front end for the lock datapath. It produces the key stream that the lock decider consumes.
- Drives a 4-row x 3-column keypad by column strobing and reads the rows.
- Debounces each press and encodes it into the 4-bit key code.
- Issues one Valid_1 pulse per accepted press, holds Code_1 stable until the next press, and drives S_Row high while the key stays held.

Parameters:
SCAN_DIV, 1000, clk cycles each column stays driven (column slot length).
DEB_CNT, 16, consecutive identical scan rounds required to accept a press or a release.
VALID_LEN, 4, width of the Valid_1 pulse in clk cycles.

Ports:
clk  input  1  system clock
reset_1  input  1  asynchronous, active-low reset
row_in  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk
col_out  output  3  keypad column strobes, active-low, one-cold
Code_1  output  4  encoded key, stable between accepted presses
Valid_1  output  1  press-accepted pulse, VALID_LEN cycles wide
S_Row  output  1  debounced "key held" flag

Behaviour:
- Reset: reset_1 is asynchronous, active-low; clock is clk. While reset_1 is low:
  - col_out=3'b110; Code_1=4'b0000; Valid_1=0; S_Row=0.
  - FSM goes to IDLE; all counters=0; synchronizer flops=4'b1111.
  - Assertion mid-operation aborts immediately, including a Valid_1 pulse in flight.
- Key map (row,col -> code):
  - r0: 1=0001, 2=0010, 3=0011
  - r1: 4=0100, 5=0101, 6=0110
  - r2: 7=0111, 8=1000, 9=1001
  - r3: *=1011, 0=0000, #=1010
- Scan:
  - row_in passes through a 2-flop synchronizer.
  - Column index cycles 0,1,2,0,...; col_out bit[idx] is low and the others high.
  - A slot counter (0..SCAN_DIV-1) advances the index on wrap.
  - Rows are sampled in the last cycle of each slot, to allow settling.
  - One round = 3 slots = 3*SCAN_DIV cycles.
- Round result, evaluated at the end of column-2's slot:
  - KEY(k): exactly one row/column intersection low over the round.
  - NONE: no row low in any slot.
  - MULTI: two or more intersections low.
- FSM states: IDLE, DEBOUNCE, PRESSED. All transitions happen only at round end.
  - IDLE:
    - KEY(k) -> cand=k, deb=1, go to DEBOUNCE.
    - NONE or MULTI -> stay in IDLE.
  - DEBOUNCE:
    - KEY(cand) -> deb+1.
    - When deb reaches DEB_CNT: Code_1<=cand, S_Row<=1, go to PRESSED, arm the Valid_1 pulse.
    - KEY(other), NONE or MULTI -> go to IDLE; Code_1 is unchanged.
  - PRESSED:
    - NONE -> rel+1; when rel reaches DEB_CNT: S_Row<=0, go to IDLE.
    - KEY(any) or MULTI -> rel=0.
    - A key change while held raises no new event.
- Valid_1 timing:
  - Code_1 updates at cycle T (the accept cycle).
  - Valid_1 rises at T+1 and stays high for exactly VALID_LEN cycles.
  - Code_1 is therefore stable at least one cycle before and throughout each Valid_1 rising edge.
  - Exactly one Valid_1 pulse per accepted press, regardless of hold time.
- S_Row:
  - Rises at T, together with the Code_1 update.
  - Stays high through the hold; falls only on debounced release.
- Counters:
  - Slot counter width is clog2(SCAN_DIV).
  - deb and rel saturate at DEB_CNT and never wrap.
- Minimum press-to-Valid_1 latency: DEB_CNT rounds + 1 cycle from the first round in which the key is seen.

Test Plan:
1. SCAN_DIV=4, DEB_CNT=3, VALID_LEN=4; hold '5' (row1 low while col1 driven) 5 rounds, then release -> Code_1=0101 at 3rd round end, Valid_1 high cycles T+1..T+4, S_Row=1 from T; S_Row=0 after 3 empty rounds; exactly one Valid_1.
2. Press '#', release, press '*' -> Code_1=1010 then 1011, two Valid_1 pulses; Code_1 holds 1010 between them.
3. Bounce: '7' for 2 rounds, NONE 1 round, '7' for 3 rounds -> single Valid_1 with Code_1=0111, after the second burst only.
4. '1' and '2' pressed together for 6 rounds -> no Valid_1; Code_1 keeps its prior value; S_Row=0.
5. Hold '#' 20 rounds, switch to '0' mid-hold, then release -> one Valid_1 (1010), S_Row high continuously, no event for '0'.
6. Assert reset_1 low during Valid_1 -> same cycle: Valid_1=0, S_Row=0, Code_1=0000, col_out=110; after release, scanning restarts from col0.
